// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
// Holds the FSM state encoding, the active-low 7-segment codes ({dp,g,f,e,d,c,b,a})
// and a BCD-to-segment lookup helper used by seg7_decode.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStop = 2'b10,
    StLap  = 2'b11
  } state_e;

  localparam logic [7:0] Seg0     = 8'hC0;
  localparam logic [7:0] Seg1     = 8'hF9;
  localparam logic [7:0] Seg2     = 8'hA4;
  localparam logic [7:0] Seg3     = 8'hB0;
  localparam logic [7:0] Seg4     = 8'h99;
  localparam logic [7:0] Seg5     = 8'h92;
  localparam logic [7:0] Seg6     = 8'h82;
  localparam logic [7:0] Seg7     = 8'hF8;
  localparam logic [7:0] Seg8     = 8'h80;
  localparam logic [7:0] Seg9     = 8'h90;
  localparam logic [7:0] SegDash  = 8'hBF;
  localparam logic [7:0] SegBlank = 8'hFF;

  // Position of the decimal point within the segment byte.
  localparam logic [2:0] DpBit = 3'd7;

  // Non-BCD codes (A-F) render as a dash so a corrupted digit is visible.
  function automatic logic [7:0] seg_lookup(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegDash;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control block and its surroundings.
//   btn_ss, btn_lap   : debounced button levels
//   d3..d0            : live BCD digits from stop_watch (d3 most significant)
//   sw_start, sw_clr  : run enable and one-cycle clear pulse to stop_watch
//   an, sseg          : active-low digit enables and segments {dp,g,f,e,d,c,b,a}
//   state             : FSM state for debug
// slave is the controller's view; master is the board/bench view.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       sw_start;
  logic       sw_clr;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [1:0] state;

  modport slave (
    input  btn_ss, btn_lap, d3, d2, d1, d0,
    output sw_start, sw_clr, an, sseg, state
  );

  modport master (
    output btn_ss, btn_lap, d3, d2, d1, d0,
    input  sw_start, sw_clr, an, sseg, state
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
//   bcd_i   : 4-bit digit value (values above 9 show a dash)
//   blank_i : force all segments off
//   dp_i    : light the decimal point
//   sseg_o  : segments {dp,g,f,e,d,c,b,a}, active-low
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] sseg_o
);

  always_comb begin
    sseg_o = blank_i ? SegBlank : seg_lookup(bcd_i);
    if (dp_i && !blank_i) begin
      sseg_o[DpBit] = 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and display sequencer.
// Turns the start/stop and lap/clear buttons into stop_watch's run enable and
// clear pulse via an IDLE/RUN/STOP/LAP FSM, freezes a lap snapshot while counting
// continues, and scans the four digits onto a common-anode 7-segment display.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : stopwatch_ctrl_if.slave (buttons, live digits, stop_watch controls,
//           display pins, debug state)
// Parameters:
//   SCAN_N        : each digit is lit for 2^SCAN_N cycles
//   BLANK_LEADING : blank leading zeros on digits 3 and 2
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_N        = 10,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);

  logic              btn_ss_q;
  logic              btn_lap_q;
  logic              ss_ev;
  logic              lap_ev;
  state_e            state_q;
  logic [15:0]       snap_q;
  logic              sw_clr_q;
  logic [SCAN_N+1:0] scan_q;
  logic [3:0]        an_q;
  logic [7:0]        sseg_q;

  logic [15:0]       live;
  logic [15:0]       shown;
  logic [1:0]        digit_sel;
  logic [3:0]        digit;
  logic              blank;
  logic [7:0]        seg;

  assign live   = {bus.d3, bus.d2, bus.d1, bus.d0};
  assign ss_ev  = bus.btn_ss & ~btn_ss_q;
  assign lap_ev = bus.btn_lap & ~btn_lap_q;

  // Edge-detect history resets high so a button held through reset is ignored
  // until it is released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_ss_q  <= 1'b1;
      btn_lap_q <= 1'b1;
    end else begin
      btn_ss_q  <= bus.btn_ss;
      btn_lap_q <= bus.btn_lap;
    end
  end

  // Start/stop has priority: a simultaneous lap event is dropped, so no snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      sw_clr_q <= 1'b0;
    end else begin
      sw_clr_q <= 1'b0;
      if (ss_ev) begin
        unique case (state_q)
          StIdle:  state_q <= StRun;
          StRun:   state_q <= StStop;
          StLap:   state_q <= StStop;
          StStop:  state_q <= StRun;
        endcase
      end else if (lap_ev) begin
        case (state_q)
          StRun: begin
            state_q <= StLap;
            snap_q  <= live;
          end
          StLap:   state_q <= StRun;
          StStop: begin
            state_q  <= StIdle;
            sw_clr_q <= 1'b1;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  // Digit select and blanking from the current (pre-register) scan position.
  always_comb begin
    shown     = (state_q == StLap) ? snap_q : live;
    digit_sel = scan_q[SCAN_N+1 -: 2];
    unique case (digit_sel)
      2'd0: digit = shown[3:0];
      2'd1: digit = shown[7:4];
      2'd2: digit = shown[11:8];
      2'd3: digit = shown[15:12];
    endcase
    blank = 1'b0;
    if (BLANK_LEADING) begin
      if (digit_sel == 2'd3) begin
        blank = (shown[15:12] == 4'd0);
      end else if (digit_sel == 2'd2) begin
        blank = (shown[15:8] == 8'd0);
      end
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i   (digit),
    .blank_i (blank),
    .dp_i    (digit_sel == 2'd1),
    .sseg_o  (seg)
  );

  // Registered display outputs lag the scan counter by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      an_q   <= 4'b1111;
      sseg_q <= SegBlank;
    end else begin
      scan_q <= scan_q + {{(SCAN_N+1){1'b0}}, 1'b1};
      an_q   <= ~(4'b0001 << digit_sel);
      sseg_q <= seg;
    end
  end

  assign bus.sw_start = state_q[0];
  assign bus.sw_clr   = sw_clr_q;
  assign bus.an       = an_q;
  assign bus.sseg     = sseg_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int unsigned SCAN_N = 2;
  localparam int Frame = 4 << SCAN_N;

  logic clk;
  logic reset;
  stopwatch_ctrl_if sif ();

  stopwatch_ctrl #(
    .SCAN_N        (SCAN_N),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model state
  logic [1:0]  m_state;
  logic [15:0] m_snap;
  logic        m_bss, m_blap, m_clr;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v, input bit blank, input bit dp);
    logic [7:0] s;
    if (blank) return 8'hFF;
    case (v)
      0: s = 8'hC0; 1: s = 8'hF9; 2: s = 8'hA4; 3: s = 8'hB0; 4: s = 8'h99;
      5: s = 8'h92; 6: s = 8'h82; 7: s = 8'hF8; 8: s = 8'h80; 9: s = 8'h90;
      default: s = 8'hBF;
    endcase
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    m_state = 2'b00; m_snap = '0; m_bss = 1'b1; m_blap = 1'b1; m_clr = 1'b0;
    m_an = 4'hF; m_seg = 8'hFF; m_cnt = 0; cyc = 0;
  endtask

  // One rising edge worth of behaviour: display of the pre-edge view, then buttons.
  task automatic model_edge();
    int k;
    logic [15:0] shown;
    logic [3:0] dig;
    bit blank, ss, lp;
    k     = (m_cnt >> SCAN_N) % 4;
    shown = (m_state == 2'b11) ? m_snap : {sif.d3, sif.d2, sif.d1, sif.d0};
    dig   = shown[4*k +: 4];
    blank = (k == 3 && shown[15:12] == 0) || (k == 2 && shown[15:8] == 0);
    m_an  = ~(4'b0001 << k);
    m_seg = seg_of(dig, blank, k == 1);
    m_cnt = (m_cnt + 1) % Frame;
    ss = sif.btn_ss && !m_bss;
    lp = sif.btn_lap && !m_blap;
    m_bss = sif.btn_ss; m_blap = sif.btn_lap;
    m_clr = 1'b0;
    if (ss) begin
      m_state = (m_state == 2'b00 || m_state == 2'b10) ? 2'b01 : 2'b10;
    end else if (lp) begin
      if (m_state == 2'b01) begin
        m_state = 2'b11; m_snap = {sif.d3, sif.d2, sif.d1, sif.d0};
      end else if (m_state == 2'b11) begin
        m_state = 2'b01;
      end else if (m_state == 2'b10) begin
        m_state = 2'b00; m_clr = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("cycle", {16'h0, sif.an, sif.sseg, sif.state, sif.sw_start, sif.sw_clr},
        {16'h0, m_an, m_seg, m_state, m_state[0], m_clr});
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    sif.d3 = a3; sif.d2 = a2; sif.d1 = a1; sif.d0 = a0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_an"}, {28'h0, sif.an}, 32'hF);
    chk({name, "_sseg"}, {24'h0, sif.sseg}, 32'hFF);
    chk({name, "_state"}, {30'h0, sif.state}, 32'h0);
    chk({name, "_start_clr"}, {30'h0, sif.sw_start, sif.sw_clr}, 32'h0);
  endtask

  // Run one full frame, checking each digit's segments against a hand table.
  task automatic frame_lit(input string name, input logic [31:0] segs);
    int k;
    logic [31:0] tbl;
    tbl = segs;
    for (int i = 0; i < Frame; i++) begin
      step();
      k = ((cyc - 1) >> SCAN_N) % 4;
      chk(name, {24'h0, sif.sseg}, {24'h0, tbl[8*k +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] an_tbl [4];

  initial begin
    an_tbl[0] = 4'b1110; an_tbl[1] = 4'b1101; an_tbl[2] = 4'b1011; an_tbl[3] = 4'b0111;
    reset = 1'b0;
    sif.btn_ss = 1'b0; sif.btn_lap = 1'b0;
    set_d(0, 0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset_hold");
    reset = 1'b1;

    // Default display: 1110/C0, 1101/40, 1011/FF, 0111/FF, four cycles each.
    for (int i = 0; i < Frame; i++) begin
      step();
      chk("dflt_an", {28'h0, sif.an}, {28'h0, an_tbl[i / 4]});
    end
    chk("dflt_seg_last", {24'h0, sif.sseg}, 32'hFF);

    // Start / stop
    sif.btn_ss = 1'b1; step();
    chk("start_state", {30'h0, sif.state}, 32'h1);
    chk("start_en", {31'h0, sif.sw_start}, 32'h1);
    sif.btn_ss = 1'b0; step();
    sif.btn_ss = 1'b1; step();
    chk("stop_state", {30'h0, sif.state}, 32'h2);
    chk("stop_en", {31'h0, sif.sw_start}, 32'h0);
    sif.btn_ss = 1'b0; step();

    // Lap freeze
    sif.btn_ss = 1'b1; step(); sif.btn_ss = 1'b0; step();
    set_d(1, 2, 3, 4);
    sif.btn_lap = 1'b1; step();
    chk("lap_state", {30'h0, sif.state}, 32'h3);
    sif.btn_lap = 1'b0;
    set_d(5, 6, 7, 8);
    frame_lit("lap_frozen", {8'hF9, 8'hA4, 8'h30, 8'h99});
    chk("lap_run_en", {31'h0, sif.sw_start}, 32'h1);
    sif.btn_lap = 1'b1; step(); sif.btn_lap = 1'b0; step();
    chk("lap_release", {30'h0, sif.state}, 32'h1);
    frame_lit("lap_live", {8'h92, 8'h82, 8'h78, 8'h80});

    // Clear from STOP
    sif.btn_ss = 1'b1; step(); sif.btn_ss = 1'b0; step();
    sif.btn_lap = 1'b1; step();
    chk("clr_pulse", {31'h0, sif.sw_clr}, 32'h1);
    chk("clr_state", {30'h0, sif.state}, 32'h0);
    sif.btn_lap = 1'b0; step();
    chk("clr_low", {31'h0, sif.sw_clr}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sif.btn_lap = 1'b1; step(); sif.btn_lap = 1'b0; step();
    end
    chk("idle_lap_ign", {30'h0, sif.state}, 32'h0);

    // Simultaneous events in RUN: start/stop wins
    sif.btn_ss = 1'b1; step(); sif.btn_ss = 1'b0; step();
    set_d(9, 9, 9, 9);
    sif.btn_ss = 1'b1; sif.btn_lap = 1'b1; step();
    chk("simul_state", {30'h0, sif.state}, 32'h2);
    chk("simul_clr", {31'h0, sif.sw_clr}, 32'h0);
    sif.btn_ss = 1'b0; sif.btn_lap = 1'b0; step();

    // Non-BCD digit shows a dash
    set_d(0, 0, 0, 4'hC);
    frame_lit("dash", {8'hFF, 8'hFF, 8'h40, 8'hBF});

    // Button held through reset release
    @(negedge clk);
    reset = 1'b0; sif.btn_ss = 1'b1;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("held_reset");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("held_no_trans", {30'h0, sif.state}, 32'h0);
    sif.btn_ss = 1'b0; step();
    sif.btn_ss = 1'b1; step();
    chk("held_repress", {30'h0, sif.state}, 32'h1);
    sif.btn_ss = 1'b0; step();

    // Async reset while in LAP
    set_d(2, 0, 4, 1);
    sif.btn_lap = 1'b1; step(); sif.btn_lap = 1'b0; step();
    chk("pre_reset_lap", {30'h0, sif.state}, 32'h3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_reset_an", {28'h0, sif.an}, 32'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and display sequencer for the `stop_watch` BCD counter. It turns two pre-debounced push-button levels into the counter's run enable and clear pulse, and tracks an IDLE/RUN/LAP/STOP state machine. It can freeze a lap snapshot while counting continues, and time-multiplexes the four BCD digits onto one common-anode 7-segment display. It sits between the board buttons and `stop_watch`, and its outputs drive the display pins directly.

## Interface
- `SCAN_N`, 10: each digit is active for 2^SCAN_N cycles.
- `BLANK_LEADING`, 1: enables leading-zero blanking on digits 3 and 2.

- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `btn_ss`  in  1  start/stop button level; synchronous and debounced upstream.
- `btn_lap`  in  1  lap/clear button level; synchronous and debounced upstream.
- `d3`,`d2`,`d1`,`d0`  in  4 each  live BCD digits from `stop_watch`; d3 is the most significant.
- `sw_start`  out  1  run enable to `stop_watch`.
- `sw_clr`  out  1  one-cycle clear pulse to `stop_watch`, active-high.
- `an`  out  4  digit enables, active-low; an[i] selects digit i.
- `sseg`  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `state`  out  2  current FSM state, for debug.

## Operation
- **Button edge detect**
  - Each button level is registered (`btn_q`).
  - An event is `btn & ~btn_q`.
  - `btn_q` resets to 1, so a button held through reset is ignored until it is released and pressed again.
- **State encoding**: IDLE=00, RUN=01, STOP=10, LAP=11. `sw_start` = state[0].
- **Transitions**
  - IDLE: ss → RUN. lap is ignored.
  - RUN: ss → STOP. lap → LAP, and the snapshot captures {d3,d2,d1,d0}.
  - LAP: lap → RUN (freeze released). ss → STOP (freeze released, live value shown).
  - STOP: ss → RUN. lap → IDLE with `sw_clr` asserted.
- **Simultaneous events**: if ss and lap events occur in the same cycle, ss wins and lap is discarded, so no snapshot is taken.
- **Displayed value**: the snapshot while in LAP, otherwise the live digits.
- **Scan counter**
  - Free-running, SCAN_N+2 bits, wraps; runs in every state.
  - Top 2 bits select digit k; `an` = ~(1<<k).
- **Segment codes**
  - BCD 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Any value above 9: BF (dash).
  - Blanked digit: FF.
  - The dp bit (bit7) is cleared on digit 1 only.
- **Blanking** (when BLANK_LEADING=1)
  - Digit 3 is blank if its value is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digits 1 and 0 are never blanked.

## Timing
- **Reset values**: state=IDLE, `sw_start`=0, `sw_clr`=0, `an`=1111, `sw_clr` register 0, `sseg`=FF, scan counter 0, snapshot 0, `btn_q`=1.
- **Button to state**: a button sampled high at rising edge k while `btn_q`=0 updates state at edge k. `sw_start` follows immediately, since it is a state bit and glitch-free.
- **Snapshot**: loaded at the same edge k, from the d inputs present at k.
- **Clear pulse**: `sw_clr` is registered; it goes high at edge k of the STOP→IDLE transition and low at edge k+1. It is never high in any other case.
- **Display latency**: `an`/`sseg` are registered, one cycle after the scan counter/data.
  - Each digit is shown for exactly 2^SCAN_N cycles.
  - A full frame is 4·2^SCAN_N cycles.
- **Reset mid-operation**: asserting `reset` at any point, including in LAP or during the `sw_clr` pulse, forces all reset values asynchronously. After release the block starts in IDLE.

## Structure
- Shared package/include `stopwatch_pkg`:
  - state encodings
  - segment constants (digits 0–9, dash, blank)
  - dp bit index
- Sub-module `seg7_decode`: combinational 4-bit BCD + blank + dp → 8-bit active-low segments. It is instantiated once, after the digit mux.
- The FSM, edge detect, snapshot register, scan counter and output registers live in `stopwatch_ctrl`.

## Test plan
All scenarios use SCAN_N=2.
- **Reset and default display**: hold `reset`=0 with d=0,0,0,0, then release.
  - During reset, `an`=1111 and `sseg`=FF.
  - Afterwards the display cycles: an 1110/C0, an 1101/40, an 1011/FF, an 0111/FF, each lasting 4 cycles.
- **Start/stop**: ss pulse → `sw_start`=1 and state=01 in the same cycle. A second pulse → `sw_start`=0 and state=10.
- **Lap freeze**: in RUN with d=1,2,3,4, pulse lap, then drive d=5,6,7,8.
  - Display stays at digit3 F9, digit2 A4, digit1 30, digit0 99, and `sw_start`=1.
  - A second lap → display shows 5,6,7,8.
- **Clear**: in STOP, pulse lap → `sw_clr` is high for exactly 1 cycle and state=00. Extra lap pulses in IDLE do nothing.
- **Edge cases**
  - ss and lap events in the same cycle while in RUN → state=10, no snapshot.
  - Button held through reset release → no transition.
  - d0=C → digit0 shows BF.
- **Async reset mid-LAP**: assert `reset` between clock edges → all outputs return to their reset values immediately.
